// File: rtl/song_sequencer_if.sv
// song_sequencer_if: play control, song ROM port and note-player handshake
interface song_sequencer_if #(parameter int NOTE_IDX_W = 5);
  logic                  play;
  logic [1:0]            song;
  logic [NOTE_IDX_W+1:0] rom_addr;
  logic [11:0]           rom_data;
  logic [5:0]            note_to_load;
  logic [5:0]            duration_to_load;
  logic                  load_new_note;
  logic                  done_with_note;
  logic                  song_done;
  modport master (
    output play, song, rom_data, done_with_note,
    input  rom_addr, note_to_load, duration_to_load, load_new_note, song_done
  );
  modport slave (
    input  play, song, rom_data, done_with_note,
    output rom_addr, note_to_load, duration_to_load, load_new_note, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM and feeds notes to the note player; SONG_END_MARKER_EN ends a song on a zero duration
module song_sequencer #(parameter int NOTE_IDX_W = 5) (
  input logic             clk,
  input logic             reset,
  song_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, READ, LOAD, WAIT, DONE} state_t;
  state_t                state, state_nxt;
  logic                  play_q;
  logic [1:0]            song_q;
  logic [NOTE_IDX_W-1:0] note_idx;
  logic [5:0]            note, duration;
  logic                  load;
  logic                  start, last, end_marker;
  assign start = bus.play & ~play_q;
  assign last  = &note_idx;
`ifdef SONG_END_MARKER_EN
  assign end_marker = bus.rom_data[5:0] == 6'd0;
`else
  assign end_marker = 1'b0;
`endif
  assign bus.rom_addr         = {song_q, note_idx};
  assign bus.note_to_load     = note;
  assign bus.duration_to_load = duration;
  assign bus.load_new_note    = load;
  assign bus.song_done        = state == DONE;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: LOAD holds while paused, WAIT advances only on done_with_note
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = READ;
      READ:    state_nxt = end_marker ? DONE : LOAD;
      LOAD:    state_nxt = bus.play ? WAIT : LOAD;
      WAIT:    state_nxt = bus.done_with_note ? (last ? DONE : FETCH) : WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: song latch, note index, captured ROM word and registered load strobe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      play_q   <= 1'b0;
      song_q   <= '0;
      note_idx <= '0;
      note     <= '0;
      duration <= '0;
      load     <= 1'b0;
    end else begin
      play_q <= bus.play;
      load   <= state == LOAD && bus.play;
      if (state == IDLE && start) begin
        song_q   <= bus.song;
        note_idx <= '0;
      end
      if (state == READ) begin
        note     <= bus.rom_data[11:6];
        duration <= bus.rom_data[5:0];
      end
      if (state == WAIT && bus.done_with_note && !last) note_idx <= note_idx + 1'b1;
      if (state == DONE) note_idx <= '0;
    end
endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter NOTE_IDX_W, default 5: width of the note index within a song (2**NOTE_IDX_W entries per song).
REQ-002 SHALL have port clk  input  1: system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port play  input  1: play request; a rising edge starts a song, and low pauses sequencing.
REQ-005 SHALL have port song  input  2: song select, latched when a song starts.
REQ-006 SHALL have port rom_addr  output  2+NOTE_IDX_W: song ROM address {song_q, note_idx}.
REQ-007 SHALL have port rom_data  input  12: ROM word {note[11:6], duration[5:0]}, valid one cycle after rom_addr.
REQ-008 SHALL have port note_to_load  output  6: note presented to the note player.
REQ-009 SHALL have port duration_to_load  output  6: duration in beats presented to the note player.
REQ-010 SHALL have port load_new_note  output  1: one-cycle load strobe to the note player.
REQ-011 SHALL have port done_with_note  input  1: note player finished the current note.
REQ-012 SHALL have port song_done  output  1: one-cycle pulse when a song completes.

Function
REQ-013 SHALL implement states IDLE, FETCH, READ, LOAD, WAIT, DONE.
REQ-014 SHALL register play as play_q, with start = play & ~play_q.
REQ-015 In IDLE, start SHALL latch song into song_q, clear note_idx, and go to FETCH; otherwise the block SHALL stay in IDLE.
REQ-016 In FETCH, rom_addr SHALL equal {song_q, note_idx}, and the next state SHALL be READ.
REQ-017 In READ, the block SHALL capture rom_data[11:6] into note_to_load and rom_data[5:0] into duration_to_load, then go to LOAD.
REQ-018 In LOAD, load_new_note SHALL be high for exactly one cycle when play=1, followed by a move to WAIT; with play=0 the block SHALL hold LOAD with the strobe low.
REQ-019 In WAIT, done_with_note=1 SHALL go to DONE when note_idx is all-ones; otherwise note_idx SHALL increment and the block SHALL go to FETCH.
REQ-020 done_with_note SHALL be ignored in every state other than WAIT.
REQ-021 DONE SHALL assert song_done for one cycle, clear note_idx, and go to IDLE; replay SHALL require a new play rising edge.
REQ-022 Latency SHALL be fixed: load_new_note rises exactly 3 cycles after start is sampled, and exactly 3 cycles after done_with_note is sampled in WAIT (play held high).
REQ-023 note_idx SHALL never wrap within a song; all-ones is the terminal index.
REQ-024 A change of song while not in IDLE SHALL be ignored until the next start.
REQ-025 note_to_load and duration_to_load SHALL hold their values from READ until the next READ.

Reset
REQ-026 Asserting reset (low) SHALL asynchronously force state IDLE, with note_idx, song_q, play_q, note_to_load, duration_to_load, load_new_note, song_done and rom_addr all set to 0.
REQ-027 Reset asserted mid-song SHALL abandon the song without a song_done pulse.
REQ-028 After release, a play input already high SHALL count as a rising edge, because play_q resets to 0.

Configuration
REQ-029 The macro SONG_END_MARKER_EN SHALL control end-of-song detection.
REQ-030 With SONG_END_MARKER_EN defined, a READ with rom_data[5:0]==0 SHALL go straight to DONE with no load strobe, ending the song early.
REQ-031 Without SONG_END_MARKER_EN, a zero-duration entry SHALL be loaded like any other note, and the song SHALL end only after the all-ones index.

Verification
REQ-032 Reset low with play=1, then reset high -> IDLE to FETCH on the next edge; rom_addr=0, then load_new_note high 3 cycles later.
REQ-033 song=2, rom_data=12'h042 at index 0 -> note_to_load=1, duration_to_load=2, and one load_new_note pulse; rom_addr=7'h40.
REQ-034 done_with_note pulsed at index 31 -> song_done high for one cycle, then IDLE; play still high produces no restart until play goes low and then high again.
REQ-035 play dropped during LOAD for 5 cycles -> no strobe during the pause; exactly one strobe after play returns high; done_with_note pulsed during FETCH has no effect.
REQ-036 With SONG_END_MARKER_EN defined, index 3 returns duration 0 -> song_done pulses after 3 notes and load_new_note is never asserted for index 3; without the macro, index 3 is loaded.
REQ-037 reset pulsed low while in WAIT at index 10 -> all outputs are 0 immediately, and there is no song_done pulse.
